// File: rtl/fft_ctrl_if.sv
// Index/strobe bundle between fft_ctrl and the address LUT / butterfly datapath.
// FFT_CTRL_STALL_EN adds the stall input.
interface fft_ctrl_if;
  logic       start;
  logic [1:0] stage;
  logic [2:0] butterfly;
  logic       rd_en;
  logic       wr_en;
  logic [1:0] wr_stage;
  logic [2:0] wr_butterfly;
  logic       busy;
  logic       done;
`ifdef FFT_CTRL_STALL_EN
  logic       stall;
`endif

  modport master (
`ifdef FFT_CTRL_STALL_EN
    input  stall,
`endif
    input  start,
    output stage, butterfly, rd_en, wr_en, wr_stage, wr_butterfly, busy, done
  );

  modport slave (
`ifdef FFT_CTRL_STALL_EN
    output stall,
`endif
    output start,
    input  stage, butterfly, rd_en, wr_en, wr_stage, wr_butterfly, busy, done
  );
endinterface

// File: rtl/fft_ctrl.sv
// Sequencer for the in-place radix-2 16-point FFT: 4 stages x 8 butterflies, tag pipeline
// matched to BF_LAT. Optional freeze input enabled by defining FFT_CTRL_STALL_EN.
module fft_ctrl #(
  parameter int BF_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  fft_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] stage;
    logic [2:0] bf;
  } tag_t;

  localparam int              CW    = 4;
  localparam logic [CW-1:0]   DLAST = CW'(BF_LAT - 1);

  state_t          state_q;
  logic [1:0]      stage_q;
  logic [2:0]      bf_q;
  logic [CW-1:0]   dcnt_q;
  logic            rd_en_q, busy_q, done_q;
  logic            adv;

  tag_t [BF_LAT-1:0] pipe_q, pipe_d;

`ifdef FFT_CTRL_STALL_EN
  assign adv = ~bus.stall;
`else
  assign adv = 1'b1;
`endif

  // Everything (FSM, counters, tags) freezes when adv is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      bf_q    <= '0;
      dcnt_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (adv) begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= READ;
            stage_q <= '0;
            bf_q    <= '0;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        READ: begin
          if (bf_q == 3'd7) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
            dcnt_q  <= '0;
          end else begin
            bf_q <= bf_q + 3'd1;
          end
        end
        DRAIN: begin
          // Last drain cycle coincides with the stage's final write-back.
          if (dcnt_q == DLAST) begin
            if (stage_q == 2'd3) begin
              state_q <= FIN;
              stage_q <= '0;
              bf_q    <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
              stage_q <= stage_q + 2'd1;
              bf_q    <= '0;
              rd_en_q <= 1'b1;
            end
          end else begin
            dcnt_q <= dcnt_q + CW'(1);
          end
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = '{vld: rd_en_q, stage: stage_q, bf: bf_q};
    for (int i = 1; i < BF_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst)      pipe_q <= '0;
    else if (adv) pipe_q <= pipe_d;
  end

  assign bus.stage        = stage_q;
  assign bus.butterfly    = bf_q;
  assign bus.rd_en        = rd_en_q & adv;
  assign bus.wr_en        = pipe_q[BF_LAT-1].vld & adv;
  assign bus.wr_stage     = pipe_q[BF_LAT-1].stage;
  assign bus.wr_butterfly = pipe_q[BF_LAT-1].bf;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q & adv;

endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl: three instances (BF_LAT 1/3/8) checked every cycle against a
// phase-position model, plus directed literal timing checks.
`timescale 1ns/1ps
module tb_fft_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  bit log_en = 1'b0;

  int done_cnt [3];
  int done_at  [3];
  int         rd_cyc [$];
  int         wr_cyc [$];
  logic [4:0] rd_tag [$];
  logic [4:0] wr_tag [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rel=%0d got %0d want %0d", nm, cyc - base, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 8);
    localparam int P = 8 + L;

    fft_ctrl_if u_if ();
    assign u_if.start = start;
`ifdef FFT_CTRL_STALL_EN
    assign u_if.stall = stall;
`endif

    fft_ctrl #(.BF_LAT(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.master)
    );

    // c: 0 idle, 1..4P position inside the transform, 4P+1 the done cycle
    int c = 0;
    always @(posedge clk) begin
      if (rst)             c <= 0;
      else if (stall)      c <= c;
      else if (c == 0)     c <= start ? 1 : 0;
      else if (c == 4*P+1) c <= 0;
      else                 c <= c + 1;
    end

    bit         prev_wr = 1'b0;
    bit         prev_stall = 1'b0;
    logic [2:0] prev_wbf = '0;

    always @(negedge clk) begin
      int r, s;
      bit act, e_rd, e_wr;
      act  = (c >= 1) && (c <= 4*P);
      r    = act ? (c - 1) % P : 0;
      s    = act ? (c - 1) / P : 0;
      e_rd = act && (r < 8) && !stall;
      e_wr = act && (r >= L) && (r < L + 8) && !stall;
      chk($sformatf("rd_en[L%0d]", L), 32'(u_if.rd_en), 32'(e_rd));
      chk($sformatf("wr_en[L%0d]", L), 32'(u_if.wr_en), 32'(e_wr));
      chk($sformatf("busy[L%0d]", L),  32'(u_if.busy),  32'(act));
      chk($sformatf("done[L%0d]", L),  32'(u_if.done),  32'((c == 4*P+1) && !stall));
      if (e_rd && u_if.rd_en)
        chk($sformatf("rd_tag[L%0d]", L), 32'({u_if.stage, u_if.butterfly}), 32'(s*8 + r));
      if (e_wr && u_if.wr_en)
        chk($sformatf("wr_tag[L%0d]", L), 32'({u_if.wr_stage, u_if.wr_butterfly}), 32'(s*8 + r - L));
      if (c == 0)
        chk($sformatf("idle_idx[L%0d]", L), 32'({u_if.stage, u_if.butterfly}), 32'd0);
      if (u_if.rd_en && u_if.butterfly == 3'd0 && u_if.stage != 2'd0 && !prev_stall)
        chk($sformatf("gap[L%0d]", L), 32'({prev_wr, prev_wbf}), 32'd15);
      prev_wr    = u_if.wr_en;
      prev_wbf   = u_if.wr_butterfly;
      prev_stall = stall;
      if (log_en) begin
        if (u_if.done) begin
          done_cnt[g]++;
          done_at[g] = cyc - base;
        end
        if (g == 1) begin
          if (u_if.rd_en) begin rd_cyc.push_back(cyc - base); rd_tag.push_back({u_if.stage, u_if.butterfly}); end
          if (u_if.wr_en) begin wr_cyc.push_back(cyc - base); wr_tag.push_back({u_if.wr_stage, u_if.wr_butterfly}); end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic begin_log();
    base = cyc;
    log_en = 1'b1;
    rd_cyc.delete(); wr_cyc.delete(); rd_tag.delete(); wr_tag.delete();
    for (int i = 0; i < 3; i++) begin done_cnt[i] = 0; done_at[i] = -1; end
  endtask

  task automatic run_to(input int rel);
    while (cyc - base < rel) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    int n;
    // Nominal run with literal timing from the test plan
    do_reset();
    begin_log();
    pulse_start();
    run_to(70);
    chk("done_cnt_L1", done_cnt[0], 1);
    chk("done_cnt_L3", done_cnt[1], 1);
    chk("done_cnt_L8", done_cnt[2], 1);
    chk("done_at_L1", done_at[0], 37);
    chk("done_at_L3", done_at[1], 45);
    chk("done_at_L8", done_at[2], 65);
    chk("rd_count", rd_cyc.size(), 32);
    chk("wr_count", wr_cyc.size(), 32);
    if (rd_cyc.size() == 32 && wr_cyc.size() == 32) begin
      chk("rd_first", rd_cyc[0], 1);
      chk("rd_s0_last", rd_cyc[7], 8);
      chk("rd_s1_first", rd_cyc[8], 12);
      chk("rd_last", rd_cyc[31], 41);
      chk("wr_first", wr_cyc[0], 4);
      chk("wr_last", wr_cyc[31], 44);
      for (int i = 0; i < 32; i++) begin
        chk("rd_cycle", rd_cyc[i], 1 + (i / 8) * 11 + (i % 8));
        chk("rd_seq", 32'(rd_tag[i]), i);
        chk("wr_delay", wr_cyc[i], rd_cyc[i] + 3);
        chk("wr_tagmatch", 32'(wr_tag[i]), 32'(rd_tag[i]));
      end
    end

    // Starts during a transform are ignored
    do_reset();
    begin_log();
    pulse_start();
    run_to(10); pulse_start();
    run_to(40); pulse_start();
    run_to(55);
    chk("ign_done_cnt", done_cnt[1], 1);
    chk("ign_done_at", done_at[1], 45);

    // Reset in cycle 20, restart at cycle 25
    do_reset();
    begin_log();
    pulse_start();
    run_to(20);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_out_L1", 32'({g_dut[0].u_if.rd_en, g_dut[0].u_if.wr_en, g_dut[0].u_if.busy, g_dut[0].u_if.done,
                           g_dut[0].u_if.stage, g_dut[0].u_if.butterfly, g_dut[0].u_if.wr_stage, g_dut[0].u_if.wr_butterfly}), 0);
    chk("rst_out_L3", 32'({g_dut[1].u_if.rd_en, g_dut[1].u_if.wr_en, g_dut[1].u_if.busy, g_dut[1].u_if.done,
                           g_dut[1].u_if.stage, g_dut[1].u_if.butterfly, g_dut[1].u_if.wr_stage, g_dut[1].u_if.wr_butterfly}), 0);
    chk("rst_out_L8", 32'({g_dut[2].u_if.rd_en, g_dut[2].u_if.wr_en, g_dut[2].u_if.busy, g_dut[2].u_if.done,
                           g_dut[2].u_if.stage, g_dut[2].u_if.butterfly, g_dut[2].u_if.wr_stage, g_dut[2].u_if.wr_butterfly}), 0);
    run_to(25);
    pulse_start();
    chk("restart_rd", 32'(g_dut[1].u_if.rd_en), 1);
    chk("restart_idx", 32'({g_dut[1].u_if.stage, g_dut[1].u_if.butterfly}), 0);
    run_to(40);
    n = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] >= 21 && wr_cyc[i] <= 28) n++;
    chk("no_wr_after_rst", n, 0);
    n = -1;
    foreach (wr_cyc[i]) if (n < 0 && wr_cyc[i] >= 21) n = wr_cyc[i];
    chk("restart_first_wr", n, 29);

`ifdef FFT_CTRL_STALL_EN
    // Stall held for cycles 5..7
    do_reset();
    begin_log();
    pulse_start();
    run_to(5);
    stall = 1'b1;
    tick(); tick(); tick();
    stall = 1'b0;
    chk("stall_rd_bf4", 32'({g_dut[1].u_if.rd_en, g_dut[1].u_if.butterfly}), 32'({1'b1, 3'd4}));
    run_to(60);
    n = 0;
    foreach (rd_cyc[i]) if (rd_cyc[i] >= 5 && rd_cyc[i] <= 7) n++;
    foreach (wr_cyc[i]) if (wr_cyc[i] >= 5 && wr_cyc[i] <= 7) n++;
    chk("stall_quiet", n, 0);
    chk("stall_done_at", done_at[1], 48);
    chk("stall_done_cnt", done_cnt[1], 1);
`endif

    // Random start/reset/stall traffic against the model
    do_reset();
    log_en = 1'b0;
    repeat (4000) begin
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 299) == 0);
`ifdef FFT_CTRL_STALL_EN
      stall = ($urandom_range(0, 5) == 0);
`endif
      tick();
    end
    do_reset();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
